jpeg_block_to_raster: RTL
=========================

Name: jpeg_block_to_raster

Overview:
- Downstream of the JPEG synthesis top. Consumes reconstructed 8x8 blocks, one 8-pixel block row per beat (the top's `data_out` stream).
- Re-orders them into raster order: full image lines, 8 pixels per beat, left to right.
- Uses a ping-pong pair of block-strip buffers. One strip is written while the other is drained through a valid/ready output.
- Flags overflow, because the upstream pipeline cannot stall.

Parameters:
- IMG_W_BLOCKS, 4, image width in 8x8 blocks (>=2); one strip = 8 lines x IMG_W_BLOCKS segments.
- IMG_H_BLOCKS, 4, image height in 8x8 blocks (>=1); strips per frame.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  in_data carries one block row this cycle.
- in_data  in  64  8 pixels x 8 bit; [63:56] = leftmost pixel.
- in_ready  out  1  write bank is free; a beat with in_valid=1 while in_ready=0 is dropped.
- out_valid  out  1  out_data holds a valid raster segment.
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready.
- out_data  out  64  8 raster pixels; [63:56] = leftmost.
- out_line  out  $clog2(8*IMG_H_BLOCKS)  image line of the current beat.
- out_seg  out  $clog2(IMG_W_BLOCKS)  8-pixel segment index within the line.
- out_last  out  1  current beat is the last of the frame.
- overflow  out  1  sticky; a beat was dropped.

Behaviour:
- Storage:
  - 2 banks x 8 lines x IMG_W_BLOCKS segments x 64 bit.
  - State: `full[1:0]`, write bank `wb`, read bank `rb`, write counter `wcnt` (0..8W-1), read counter `rcnt` (0..8W-1), read strip counter `rstrip` (0..H-1).
- Reset (asynchronous): `wb`=`rb`=0, `full`=00, all counters 0, storage 0, `overflow`=0.
  - Outputs in reset: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_line`=0, `out_seg`=0, `out_last`=0.
  - Reset asserted mid-strip or mid-drain discards all buffered data. No partial output after release.
- Write side:
  - `in_ready` = `!full[wb]`.
  - Input order is block-major: beat k = b*8 + r, i.e. block b (0..W-1), block row r (0..7).
  - On `in_valid & in_ready`: store `in_data` at bank `wb`, line r, segment b, then increment `wcnt`.
  - When `wcnt` = 8W-1 is written: `full[wb]`<=1, `wb` toggles, `wcnt`<=0.
  - On `in_valid & !in_ready`: beat dropped, `wcnt` unchanged, `overflow`<=1 (held until reset).
- Read side:
  - `out_valid` = `full[rb]`. Read order is `rcnt` = line*W + seg.
  - `out_data` = bank `rb`[line][seg]. `out_line` = `rstrip`*8 + line. `out_seg` = seg.
  - `out_data`, `out_line` and `out_seg` are held stable while `out_valid & !out_ready`.
  - On handshake: `rcnt`++.
  - On handshake at `rcnt` = 8W-1: `full[rb]`<=0, `rb` toggles, `rcnt`<=0, `rstrip`++. `rstrip` wraps to 0 after H-1.
  - `out_last` = `out_valid` & (`rstrip` = H-1) & (`rcnt` = 8W-1).
- Latency: `out_valid` rises the cycle after the clock edge that writes a strip's final beat.
  - With `out_ready`=1 held, a strip drains in 8W consecutive cycles.
- Simultaneous events:
  - Setting `full[wb]` and clearing `full[rb]` in the same cycle on different banks: both take effect.
  - Writing a strip's last beat in the same cycle as the other bank's last read: no loss, and `out_valid` stays high across the bank switch.
  - The same bank is never both set and cleared in one cycle (guaranteed by `in_ready`).
- Frame wrap: `out_line` wraps to 0 after line 8H-1. Frames are back-to-back with no gap requirement.
- Throughput: the output sustains 1 beat/cycle, which matches the input rate, so overflow occurs only under output backpressure.

Test Plan:
- Reset mid-strip:
  - Stimulus: W=2, write 5 beats, pulse reset, then write 16 beats with in_data = {b,r,6'h0...}.
  - Required: first output is block0 row0, `out_line`=0, `out_seg`=0; no remnant of the first 5 beats; `overflow`=0.
- Single-strip reorder:
  - Stimulus: W=2, H=2, 16 beats with in_data[63:56] = 8*b + r, `out_ready`=1.
  - Required: `out_valid` rises 1 cycle after beat 16; `out_data`[63:56] sequence is 0,8,1,9,2,10,...,7,15; `out_line` runs 0..7; `out_seg` alternates 0/1.
- Backpressure hold:
  - Stimulus: drop `out_ready` for 5 cycles at `rcnt`=3.
  - Required: `out_data`, `out_line` and `out_seg` remain unchanged for those cycles; the sequence resumes with no beat skipped or duplicated.
- Overflow:
  - Stimulus: W=2, `out_ready`=0, stream 40 contiguous beats.
  - Required: beats 1-32 stored; `in_ready`=0 from beat 33; `overflow`=1 after beat 33.
  - Then set `out_ready`=1: 32 beats out, all matching strips 0-1.
- Frame end:
  - Stimulus: W=2, H=2, `out_ready`=1, 2 frames streamed continuously.
  - Required: `out_last`=1 only on output beats 32 and 64; `out_line` on beat 33 is 0; frame 2 output identical to frame 1.
- Simultaneous bank switch:
  - Stimulus: continuous input and `out_ready`=1 so that write of beat 16n coincides with the last read of the previous strip.
  - Required: `out_valid` stays 1 across the switch; `in_ready` never 0; `overflow`=0.

Source files
------------

// File: rtl/jpeg_block_to_raster.sv
// Reorders 8x8 JPEG block rows into raster-order 8-pixel line segments
// using a ping-pong pair of block-strip buffers.
module jpeg_block_to_raster #(
  parameter int unsigned IMG_W_BLOCKS = 4,
  parameter int unsigned IMG_H_BLOCKS = 4,
  localparam int unsigned LINE_W = $clog2(8 * IMG_H_BLOCKS),
  localparam int unsigned SEG_W  = $clog2(IMG_W_BLOCKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [63:0]       in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic [LINE_W-1:0] out_line,
  output logic [SEG_W-1:0]  out_seg,
  output logic              out_last,
  output logic              overflow
);

  localparam int unsigned STRIP_W = (IMG_H_BLOCKS > 1) ? $clog2(IMG_H_BLOCKS) : 1;
  localparam logic [SEG_W-1:0]   SEG_MAX   = SEG_W'(IMG_W_BLOCKS - 1);
  localparam logic [STRIP_W-1:0] STRIP_MAX = STRIP_W'(IMG_H_BLOCKS - 1);

  logic [63:0]        mem_q [2][8][IMG_W_BLOCKS];
  logic [1:0]         full_q, full_d;
  logic               wb_q, wb_d;
  logic               rb_q, rb_d;
  logic [2:0]         wrow_q, wrow_d;
  logic [SEG_W-1:0]   wblk_q, wblk_d;
  logic [2:0]         rline_q, rline_d;
  logic [SEG_W-1:0]   rseg_q, rseg_d;
  logic [STRIP_W-1:0] rstrip_q, rstrip_d;
  logic               overflow_q, overflow_d;

  logic wr_fire, rd_fire, wr_last, rd_last;

  assign in_ready  = ~full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign wr_last   = (wrow_q == 3'd7) && (wblk_q == SEG_MAX);
  assign rd_last   = (rline_q == 3'd7) && (rseg_q == SEG_MAX);

  assign out_data = mem_q[rb_q][rline_q][rseg_q];
  assign out_line = LINE_W'({rstrip_q, rline_q});
  assign out_seg  = rseg_q;
  assign out_last = out_valid & (rstrip_q == STRIP_MAX) & rd_last;
  assign overflow = overflow_q;

  // Next-state: input arrives block-major (row fastest), output leaves line-major.
  always_comb begin
    full_d     = full_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    wrow_d     = wrow_q;
    wblk_d     = wblk_q;
    rline_d    = rline_q;
    rseg_d     = rseg_q;
    rstrip_d   = rstrip_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);

    if (wr_fire) begin
      wrow_d = wrow_q + 3'd1;
      if (wrow_q == 3'd7) begin
        wblk_d = (wblk_q == SEG_MAX) ? '0 : wblk_q + SEG_W'(1);
      end
      if (wr_last) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end

    if (rd_fire) begin
      if (rseg_q == SEG_MAX) begin
        rseg_d  = '0;
        rline_d = rline_q + 3'd1;
      end else begin
        rseg_d = rseg_q + SEG_W'(1);
      end
      if (rd_last) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rstrip_d     = (rstrip_q == STRIP_MAX) ? '0 : rstrip_q + STRIP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q     <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wrow_q     <= '0;
      wblk_q     <= '0;
      rline_q    <= '0;
      rseg_q     <= '0;
      rstrip_q   <= '0;
      overflow_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < 8; l++) begin
          for (int s = 0; s < int'(IMG_W_BLOCKS); s++) begin
            mem_q[b][l][s] <= '0;
          end
        end
      end
    end else begin
      full_q     <= full_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wrow_q     <= wrow_d;
      wblk_q     <= wblk_d;
      rline_q    <= rline_d;
      rseg_q     <= rseg_d;
      rstrip_q   <= rstrip_d;
      overflow_q <= overflow_d;
      if (wr_fire) begin
        mem_q[wb_q][wrow_q][wblk_q] <= in_data;
      end
    end
  end

endmodule
